// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard interface: pipeline-side hazard inputs and the controller's
// forwarding/stall/flush decisions.
interface pipe_hazard_ctrl_if;
  logic [4:0]  drs;
  logic [4:0]  drt;
  logic        duse_rs;
  logic        duse_rt;
  logic        dmd;
  logic        dbranch_taken;
  logic [4:0]  ern;
  logic        ewreg;
  logic        em2reg;
  logic [4:0]  mrn;
  logic        mwreg;
  logic        mm2reg;
  logic [1:0]  fwda;
  logic [1:0]  fwdb;
  logic        wpcir;
  logic        dbubble;
  logic        flush_ifid;
  logic        md_busy;
  logic [15:0] stall_cnt;

  modport master (
    output drs, drt, duse_rs, duse_rt, dmd, dbranch_taken,
    output ern, ewreg, em2reg, mrn, mwreg, mm2reg,
    input  fwda, fwdb, wpcir, dbubble, flush_ifid, md_busy, stall_cnt
  );

  modport slave (
    input  drs, drt, duse_rs, duse_rt, dmd, dbranch_taken,
    input  ern, ewreg, em2reg, mrn, mwreg, mm2reg,
    output fwda, fwdb, wpcir, dbubble, flush_ifid, md_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller beside the ID stage: operand forwarding, load-use stalls,
// multi-cycle mul/div hold, taken-branch IF/ID flush and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LAT = 8
) (
  input  logic              clock,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {StRun, StMdBusy} state_e;

  localparam logic [7:0] MdcInit = 8'(MD_LAT - 1);

  state_e      state_q;
  logic [7:0]  mdc_q;
  logic        md_busy_q;
  logic [15:0] stall_cnt_q;

  logic        lu;
  logic        issue_md;

  // EX result has priority over anything in MEM; r0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] ern, input logic ewreg, input logic em2reg,
    input logic [4:0] mrn, input logic mwreg, input logic mm2reg
  );
    if (ewreg && (ern != 5'd0) && (ern == src) && !em2reg) return 2'b01;
    if (mwreg && (mrn != 5'd0) && (mrn == src) && mm2reg)  return 2'b11;
    if (mwreg && (mrn != 5'd0) && (mrn == src))            return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    lu = hz.ewreg && hz.em2reg && (hz.ern != 5'd0) &&
         ((hz.duse_rs && (hz.ern == hz.drs)) || (hz.duse_rt && (hz.ern == hz.drt)));

    hz.fwda       = 2'b00;
    hz.fwdb       = 2'b00;
    hz.wpcir      = 1'b1;
    hz.dbubble    = 1'b0;
    hz.flush_ifid = 1'b0;
    issue_md      = 1'b0;

    if (reset) begin
      hz.wpcir   = 1'b0;
      hz.dbubble = 1'b1;
    end else begin
      hz.fwda = fwd_sel(hz.drs, hz.ern, hz.ewreg, hz.em2reg, hz.mrn, hz.mwreg, hz.mm2reg);
      hz.fwdb = fwd_sel(hz.drt, hz.ern, hz.ewreg, hz.em2reg, hz.mrn, hz.mwreg, hz.mm2reg);
      if (state_q == StMdBusy || lu) begin
        hz.wpcir   = 1'b0;
        hz.dbubble = 1'b1;
      end else begin
        hz.flush_ifid = hz.dbranch_taken;
        issue_md      = hz.dmd;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      mdc_q       <= 8'd0;
      md_busy_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (!hz.wpcir && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      unique case (state_q)
        StRun: begin
          if (issue_md) begin
            state_q   <= StMdBusy;
            mdc_q     <= MdcInit;
            md_busy_q <= 1'b1;
          end
        end
        StMdBusy: begin
          mdc_q <= mdc_q - 8'd1;
          // <= also recovers from a zero count so the FSM can never stick busy.
          if (mdc_q <= 8'd1) begin
            state_q   <= StRun;
            md_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StRun;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign hz.md_busy   = md_busy_q;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl: two instances (MD_LAT 8 and 2)
// share stimulus and are compared every checked cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipe_hazard_ctrl_if h8();
  pipe_hazard_ctrl_if h2();

  pipe_hazard_ctrl #(.MD_LAT(8)) u_dut8 (.clock(clock), .reset(reset), .hz(h8.slave));
  pipe_hazard_ctrl #(.MD_LAT(2)) u_dut2 (.clock(clock), .reset(reset), .hz(h2.slave));

  assign h2.drs           = h8.drs;
  assign h2.drt           = h8.drt;
  assign h2.duse_rs       = h8.duse_rs;
  assign h2.duse_rt       = h8.duse_rt;
  assign h2.dmd           = h8.dmd;
  assign h2.dbranch_taken = h8.dbranch_taken;
  assign h2.ern           = h8.ern;
  assign h2.ewreg         = h8.ewreg;
  assign h2.em2reg        = h8.em2reg;
  assign h2.mrn           = h8.mrn;
  assign h2.mwreg         = h8.mwreg;
  assign h2.mm2reg        = h8.mm2reg;

  int unsigned lat[2] = '{8, 2};
  int unsigned busy_rem[2];
  int unsigned cnt[2];
  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (h8.ewreg && h8.ern != 0 && h8.ern == src && !h8.em2reg) return 2'b01;
    if (h8.mwreg && h8.mrn != 0 && h8.mrn == src && h8.mm2reg)  return 2'b11;
    if (h8.mwreg && h8.mrn != 0 && h8.mrn == src)               return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit ref_lu();
    return h8.ewreg && h8.em2reg && h8.ern != 0 &&
           ((h8.duse_rs && h8.ern == h8.drs) || (h8.duse_rt && h8.ern == h8.drt));
  endfunction

  task automatic clear_inputs();
    h8.drs = 0; h8.drt = 0; h8.duse_rs = 0; h8.duse_rt = 0; h8.dmd = 0;
    h8.dbranch_taken = 0; h8.ern = 0; h8.ewreg = 0; h8.em2reg = 0;
    h8.mrn = 0; h8.mwreg = 0; h8.mm2reg = 0;
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      logic ew, eb, ef;
      logic [1:0] ea, ebb;
      logic gw, gb, gf, gm;
      logic [1:0] ga, gbb;
      logic [15:0] gc;
      bit busy;
      if (reset) begin
        busy_rem[k] = 0;
        cnt[k] = 0;
      end
      busy = busy_rem[k] != 0;
      if (reset) begin
        ew = 0; eb = 1; ef = 0; ea = 0; ebb = 0;
      end else begin
        ea  = ref_fwd(h8.drs);
        ebb = ref_fwd(h8.drt);
        ew  = !(busy || ref_lu());
        eb  = !ew;
        ef  = ew && h8.dbranch_taken;
      end
      if (k == 0) begin
        gw = h8.wpcir; gb = h8.dbubble; gf = h8.flush_ifid; gm = h8.md_busy;
        ga = h8.fwda; gbb = h8.fwdb; gc = h8.stall_cnt;
      end else begin
        gw = h2.wpcir; gb = h2.dbubble; gf = h2.flush_ifid; gm = h2.md_busy;
        ga = h2.fwda; gbb = h2.fwdb; gc = h2.stall_cnt;
      end
      check_eq($sformatf("wpcir lat%0d", lat[k]), gw, ew);
      check_eq($sformatf("dbubble lat%0d", lat[k]), gb, eb);
      check_eq($sformatf("flush_ifid lat%0d", lat[k]), gf, ef);
      check_eq($sformatf("fwda lat%0d", lat[k]), ga, ea);
      check_eq($sformatf("fwdb lat%0d", lat[k]), gbb, ebb);
      check_eq($sformatf("md_busy lat%0d", lat[k]), gm, busy);
      check_eq($sformatf("stall_cnt lat%0d", lat[k]), gc, cnt[k]);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        busy_rem[k] = 0;
        cnt[k] = 0;
      end else begin
        bit busy, lu;
        busy = busy_rem[k] != 0;
        lu   = ref_lu();
        if ((busy || lu) && cnt[k] < 65535) cnt[k]++;
        if (busy) busy_rem[k]--;
        else if (!lu && h8.dmd) busy_rem[k] = lat[k] - 1;
      end
    end
  endtask

  task automatic settle();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  initial begin
    int unsigned c8, c2;
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    clear_inputs();
    // Forwarding-worthy inputs during reset: outputs must still be the reset values.
    h8.ern = 5; h8.ewreg = 1; h8.drs = 5; h8.mrn = 5; h8.mwreg = 1;
    settle();
    check_eq("rst_wpcir", h8.wpcir, 1'b0);
    check_eq("rst_fwda", h8.fwda, 2'b00);
    advance();
    reset = 1'b0;

    // Forwarding priority
    clear_inputs();
    h8.ern = 5; h8.ewreg = 1; h8.mrn = 5; h8.mwreg = 1; h8.drs = 5; h8.drt = 0;
    settle();
    check_eq("fwd_ex_wins", h8.fwda, 2'b01);
    check_eq("fwd_b_r0", h8.fwdb, 2'b00);
    advance();
    h8.ewreg = 0;
    settle();
    check_eq("fwd_mem_alu", h8.fwda, 2'b10);
    advance();
    h8.mm2reg = 1;
    settle();
    check_eq("fwd_mem_load", h8.fwda, 2'b11);
    advance();

    // Load-use: one stall cycle, then MEM load forwarding resolves it
    clear_inputs();
    h8.ewreg = 1; h8.em2reg = 1; h8.ern = 7; h8.drt = 7; h8.duse_rt = 1;
    c8 = cnt[0];
    settle();
    check_eq("lu_wpcir", h8.wpcir, 1'b0);
    check_eq("lu_bubble", h8.dbubble, 1'b1);
    advance();
    clear_inputs();
    h8.mrn = 7; h8.mwreg = 1; h8.mm2reg = 1; h8.drt = 7; h8.duse_rt = 1;
    settle();
    check_eq("lu_resolved_wpcir", h8.wpcir, 1'b1);
    check_eq("lu_resolved_fwdb", h8.fwdb, 2'b11);
    check_eq("lu_stall_cnt", h8.stall_cnt, c8 + 1);
    advance();
    clear_inputs();
    h8.ewreg = 1; h8.em2reg = 1; h8.ern = 0; h8.drt = 0; h8.duse_rt = 1;
    settle();
    check_eq("lu_r0_no_stall", h8.wpcir, 1'b1);
    advance();

    // Branch flush, suppressed by a simultaneous load-use
    clear_inputs();
    h8.dbranch_taken = 1;
    settle();
    check_eq("br_flush", h8.flush_ifid, 1'b1);
    advance();
    h8.ewreg = 1; h8.em2reg = 1; h8.ern = 9; h8.drs = 9; h8.duse_rs = 1;
    settle();
    check_eq("br_lu_no_flush", h8.flush_ifid, 1'b0);
    advance();

    // Mul/div issue with branch: issue and flush; then busy window with branch held
    clear_inputs();
    h8.dmd = 1; h8.dbranch_taken = 1;
    c8 = cnt[0];
    c2 = cnt[1];
    settle();
    check_eq("md_issue_wpcir", h8.wpcir, 1'b1);
    check_eq("md_issue_flush", h8.flush_ifid, 1'b1);
    advance();
    h8.dmd = 0;
    for (int i = 0; i < 7; i++) begin
      settle();
      check_eq("md_busy8", h8.md_busy, 1'b1);
      check_eq("md_busy8_flush", h8.flush_ifid, 1'b0);
      advance();
    end
    settle();
    check_eq("md_done8", h8.md_busy, 1'b0);
    check_eq("md_cnt8", h8.stall_cnt, c8 + 7);
    check_eq("md_cnt2", h2.stall_cnt, c2 + 1);
    advance();

    // Back-to-back mul/div
    clear_inputs();
    h8.dmd = 1;
    for (int i = 0; i < 20; i++) step();

    // Reset in the 3rd busy cycle, asserted mid-cycle
    clear_inputs();
    h8.dmd = 1;
    step();
    h8.dmd = 0;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_md_busy", h8.md_busy, 1'b0);
    check_eq("rst_mid_stall_cnt", h8.stall_cnt, 16'd0);
    step();
    reset = 1'b0;
    settle();
    check_eq("post_rst_wpcir", h8.wpcir, 1'b1);
    advance();

    // Randomized traffic over a small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      h8.drs = 5'($urandom_range(0, 3));
      h8.drt = 5'($urandom_range(0, 3));
      h8.ern = 5'($urandom_range(0, 3));
      h8.mrn = 5'($urandom_range(0, 3));
      h8.duse_rs = 1'($urandom_range(0, 1));
      h8.duse_rt = 1'($urandom_range(0, 1));
      h8.ewreg = 1'($urandom_range(0, 1));
      h8.em2reg = 1'($urandom_range(0, 1));
      h8.mwreg = 1'($urandom_range(0, 1));
      h8.mm2reg = 1'($urandom_range(0, 1));
      h8.dbranch_taken = 1'($urandom_range(0, 1));
      h8.dmd = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    // Saturation: continuous load-use for 70000 cycles
    clear_inputs();
    h8.ewreg = 1; h8.em2reg = 1; h8.ern = 3; h8.drs = 3; h8.duse_rs = 1;
    for (int i = 0; i < 70000; i++) begin
      if (i % 4096 == 0) settle();
      else @(negedge clock);
      advance();
    end
    settle();
    check_eq("sat_cnt8", h8.stall_cnt, 16'hFFFF);
    check_eq("sat_cnt2", h2.stall_cnt, 16'hFFFF);
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage pipelined CPU. It sits beside the ID stage and sequences the ID/EX pipeline register. Each cycle it chooses operand forwarding sources, stalls the front end and injects bubbles on load-use hazards. It also holds the pipeline for a parameterised multi-cycle multiply/divide operation and flushes IF/ID on taken branches. A saturating stall counter is kept for performance monitoring.

## Interface
- MD_LAT, 8, total execute latency in cycles of a multi-cycle (mul/div) instruction; legal range 2..255.

- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- drs, drt  in  5  source register numbers of the instruction in ID.
- duse_rs, duse_rt  in  1  ID instruction actually reads rs / rt.
- dmd  in  1  ID instruction is multi-cycle mul/div.
- dbranch_taken  in  1  branch/jump in ID resolved taken this cycle.
- ern, ewreg, em2reg  in  5,1,1  EX-stage destination, write enable, load flag (from ID/EX register).
- mrn, mwreg, mm2reg  in  5,1,1  MEM-stage destination, write enable, load flag.
- fwda, fwdb  out  2  operand A/B source: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
- wpcir  out  1  PC and IF/ID write enable (0 = hold).
- dbubble  out  1  convert the instruction entering ID/EX into a bubble (wreg=wmem=0).
- flush_ifid  out  1  replace the IF/ID contents with a nop at next edge.
- md_busy  out  1  FSM in MD_BUSY.
- stall_cnt  out  16  count of cycles with wpcir=0, saturating.

## Operation
- FSM states: RUN, MD_BUSY. Down-counter mdc is 8 bits.
- Forwarding for fwda (fwdb is identical using drt):
  - 01 if ewreg & ern!=0 & ern==drs & !em2reg.
  - Otherwise 11 if mwreg & mrn!=0 & mrn==drs & mm2reg.
  - Otherwise 10 if mwreg & mrn!=0 & mrn==drs.
  - Otherwise 00.
  - EX has priority over MEM. Register 0 never forwards.
- Load-use hazard lu = ewreg & em2reg & ern!=0 & ((duse_rs & ern==drs) | (duse_rt & ern==drt)).
- RUN:
  - If lu: wpcir=0, dbubble=1, flush_ifid=0. State stays RUN. A pending dmd is not issued.
  - Else if dmd: the instruction issues normally (wpcir=1, dbubble=0). Next state is MD_BUSY with mdc=MD_LAT-1.
  - Else: wpcir=1, dbubble=0.
  - flush_ifid = dbranch_taken & wpcir.
- MD_BUSY:
  - Outputs: wpcir=0, dbubble=1, flush_ifid=0.
  - mdc decrements every cycle. When mdc==1, the next state is RUN.
  - dbranch_taken and lu are ignored. They are re-evaluated in RUN.
- stall_cnt increments on every non-reset cycle with wpcir=0 and saturates at 0xFFFF.

## Timing
- Reset (asynchronous, active-high) forces:
  - state=RUN, mdc=0, stall_cnt=0.
  - While reset is high: wpcir=0, dbubble=1, flush_ifid=0, fwda=fwdb=00, md_busy=0.
- Output timing: fwda, fwdb, wpcir, dbubble and flush_ifid are combinational from inputs and state, valid in the same cycle. md_busy and stall_cnt are registered.
- Load-use stall lasts exactly 1 cycle: the next cycle the load is in MEM and forwarding (11) resolves it.
- A mul/div issue cycle is followed by exactly MD_LAT-1 MD_BUSY cycles. Total front-end hold is MD_LAT-1 cycles.
- A back-to-back dmd after MD_BUSY issues in the first RUN cycle and re-enters MD_BUSY.
- Simultaneous events:
  - lu with dbranch_taken: the stall wins, no flush.
  - dmd with dbranch_taken (no lu): issue, flush, and enter MD_BUSY.
- Reset asserted mid-MD_BUSY: the FSM returns to RUN immediately. No residual stall after reset is released.

## Test plan
- Forwarding: ern=5, ewreg=1, em2reg=0, mrn=5, mwreg=1, drs=5, drt=0 -> fwda=01 (EX wins), fwdb=00. Then with ewreg=0 -> fwda=10. Then with mm2reg=1 -> fwda=11.
- Load-use: ewreg=em2reg=1, ern=7, drt=7, duse_rt=1 -> wpcir=0, dbubble=1 for exactly one cycle, stall_cnt +1. Repeat with ern=0 -> no stall.
- Mul/div with MD_LAT=8: dmd=1 in RUN -> issue cycle wpcir=1. Then 7 cycles with md_busy=1, wpcir=0, dbubble=1. Back to RUN and stall_cnt=7. Repeat with MD_LAT=2 -> exactly 1 busy cycle.
- Branch: dbranch_taken=1 in RUN with no hazard -> flush_ifid=1. With lu=1 the same cycle -> flush_ifid=0. During MD_BUSY -> flush_ifid=0.
- Reset mid-operation: assert reset on the 3rd MD_BUSY cycle -> md_busy=0 and stall_cnt=0 immediately. After release with dmd=0 -> wpcir=1.
- Saturation: hold lu=1 for 70000 cycles -> stall_cnt stays at 0xFFFF with no wrap.
